meta_data_barrel_rotator: RTL and testbench

META_DATA_BARREL_ROTATOR -- requirements
Module: meta_data_barrel_rotator

---
 rtl/meta_data_barrel_rotator.sv | 141 ++++++++++++++
 tb/tb_meta_data_barrel_rotator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_data_barrel_rotator.sv
// Two-stage word rotator for metadata blocks: the stage-1 register captures a request and its
// legality; stage 2 rotates and masks all four arrays together and holds the registered result.
module meta_data_barrel_rotator #(
  parameter int MAX_WORDS      = 32,
  parameter int WORD_W         = 32,
  parameter int BW_W           = 5,
  parameter int BYTES_PER_WORD = 4,
  parameter int ROT_W          = $clog2(MAX_WORDS),
  parameter int NW_W           = $clog2(MAX_WORDS) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BW_W*MAX_WORDS-1:0]           bw_in,
  input  logic [WORD_W*MAX_WORDS-1:0]         mid_in,
  input  logic [MAX_WORDS-1:0]                conv_in,
  input  logic [BYTES_PER_WORD*MAX_WORDS-1:0] bool_in,
  input  logic [ROT_W-1:0]                    rot_amt,
  input  logic                                rot_dir,
  input  logic [NW_W-1:0]                     num_words,
  output logic [BW_W*MAX_WORDS-1:0]           bw_out,
  output logic [WORD_W*MAX_WORDS-1:0]         mid_out,
  output logic [MAX_WORDS-1:0]                conv_out,
  output logic [BYTES_PER_WORD*MAX_WORDS-1:0] bool_out,
  output logic                                out_err,
  output logic                                out_valid,
  input  logic                                out_ready
);

  logic                                r_s1Valid;
  logic                                r_s1Err;
  logic [BW_W*MAX_WORDS-1:0]           r_s1Bw;
  logic [WORD_W*MAX_WORDS-1:0]         r_s1Mid;
  logic [MAX_WORDS-1:0]                r_s1Conv;
  logic [BYTES_PER_WORD*MAX_WORDS-1:0] r_s1Bool;
  logic [ROT_W-1:0]                    r_s1Rot;
  logic                                r_s1Dir;
  logic [NW_W-1:0]                     r_s1Nw;

  logic                                w_s2Adv;
  logic                                w_reqErr;
  logic [BW_W*MAX_WORDS-1:0]           w_bwRot;
  logic [WORD_W*MAX_WORDS-1:0]         w_midRot;
  logic [MAX_WORDS-1:0]                w_convRot;
  logic [BYTES_PER_WORD*MAX_WORDS-1:0] w_boolRot;
  int                                  w_src;

  assign w_s2Adv  = !out_valid | out_ready;
  assign in_ready = rst & !flush & (!r_s1Valid | w_s2Adv);
  assign w_reqErr = (num_words == '0) | (num_words > NW_W'(MAX_WORDS)) |
                    ({1'b0, rot_amt} >= num_words);

  // Since rot < N and i < N, a single conditional add/subtract of N replaces a full modulo.
  function automatic int srcIndex(input int i, input int rot, input logic dir, input int n);
    int s;
    if (dir) begin
      s = (i >= rot) ? (i - rot) : (i - rot + n);
    end else begin
      s = i + rot;
      if (s >= n) s = s - n;
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1Valid <= 1'b0;
      r_s1Err   <= 1'b0;
      r_s1Bw    <= '0;
      r_s1Mid   <= '0;
      r_s1Conv  <= '0;
      r_s1Bool  <= '0;
      r_s1Rot   <= '0;
      r_s1Dir   <= 1'b0;
      r_s1Nw    <= '0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Err  <= w_reqErr;
        r_s1Bw   <= bw_in;
        r_s1Mid  <= mid_in;
        r_s1Conv <= conv_in;
        r_s1Bool <= bool_in;
        r_s1Rot  <= rot_amt;
        r_s1Dir  <= rot_dir;
        r_s1Nw   <= num_words;
      end
    end
  end

  // Illegal requests and words beyond N keep the all-zero defaults.
  always_comb begin
    w_bwRot   = '0;
    w_midRot  = '0;
    w_convRot = '0;
    w_boolRot = '0;
    w_src     = 0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (!r_s1Err && (i < int'(r_s1Nw))) begin
        w_src = srcIndex(i, int'(r_s1Rot), r_s1Dir, int'(r_s1Nw));
        w_bwRot[i*BW_W +: BW_W]                     = r_s1Bw[w_src*BW_W +: BW_W];
        w_midRot[i*WORD_W +: WORD_W]                = r_s1Mid[w_src*WORD_W +: WORD_W];
        w_convRot[i]                                = r_s1Conv[w_src];
        w_boolRot[i*BYTES_PER_WORD +: BYTES_PER_WORD] =
          r_s1Bool[w_src*BYTES_PER_WORD +: BYTES_PER_WORD];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      bw_out    <= '0;
      mid_out   <= '0;
      conv_out  <= '0;
      bool_out  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      bw_out    <= '0;
      mid_out   <= '0;
      conv_out  <= '0;
      bool_out  <= '0;
    end else if (w_s2Adv) begin
      out_valid <= r_s1Valid;
      if (r_s1Valid) begin
        out_err  <= r_s1Err;
        bw_out   <= w_bwRot;
        mid_out  <= w_midRot;
        conv_out <= w_convRot;
        bool_out <= w_boolRot;
      end
    end
  end

endmodule

// File: tb/tb_meta_data_barrel_rotator.sv
// Randomized and directed bench for meta_data_barrel_rotator, checked every cycle against a
// queue-based reference model that applies the word-rotation rules with plain modulo arithmetic.
module tb_meta_data_barrel_rotator;

  localparam int MAX_WORDS = 32;
  localparam int WORD_W    = 32;
  localparam int BW_W      = 5;
  localparam int BPW       = 4;
  localparam int BWT       = BW_W * MAX_WORDS;
  localparam int MIDT      = WORD_W * MAX_WORDS;
  localparam int BOOLT     = BPW * MAX_WORDS;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [BWT-1:0]   bw_in;
  logic [MIDT-1:0]  mid_in;
  logic [31:0]      conv_in;
  logic [BOOLT-1:0] bool_in;
  logic [4:0]       rot_amt;
  logic             rot_dir;
  logic [5:0]       num_words;
  logic [BWT-1:0]   bw_out;
  logic [MIDT-1:0]  mid_out;
  logic [31:0]      conv_out;
  logic [BOOLT-1:0] bool_out;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  meta_data_barrel_rotator dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .bw_in(bw_in), .mid_in(mid_in), .conv_in(conv_in), .bool_in(bool_in),
    .rot_amt(rot_amt), .rot_dir(rot_dir), .num_words(num_words),
    .bw_out(bw_out), .mid_out(mid_out), .conv_out(conv_out), .bool_out(bool_out),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [BWT-1:0]   bw;
    logic [MIDT-1:0]  mid;
    logic [31:0]      conv;
    logic [BOOLT-1:0] boolV;
    logic             err;
    int               cycle;
  } item_t;

  item_t q[$];
  int    assertCount = 0;
  int    failCount   = 0;
  int    cyc         = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    assertCount++;
    if (act !== exp) begin
      failCount++;
      w = 0;
      for (int i = 0; i < 32; i++) begin
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          w = i;
          break;
        end
      end
      $display("[TB] FAIL %s: word %0d got %h expected %h", name, w, act[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  // Reference: output word i takes input word (i+rot)%N or (i-rot+N)%N; everything else zero.
  function automatic item_t modelOf(input int c);
    item_t r;
    int n, rot, src;
    r.bw = '0; r.mid = '0; r.conv = '0; r.boolV = '0; r.cycle = c;
    n   = int'(num_words);
    rot = int'(rot_amt);
    r.err = !(n >= 1 && n <= MAX_WORDS && rot < n);
    if (!r.err) begin
      for (int i = 0; i < n; i++) begin
        src = rot_dir ? (i - rot + n) % n : (i + rot) % n;
        r.bw[i*BW_W +: BW_W]      = bw_in[src*BW_W +: BW_W];
        r.mid[i*WORD_W +: WORD_W] = mid_in[src*WORD_W +: WORD_W];
        r.conv[i]                 = conv_in[src];
        r.boolV[i*BPW +: BPW]     = bool_in[src*BPW +: BPW];
      end
    end
    return r;
  endfunction

  // Per-cycle comparison: an accepted item becomes visible two negedges after its handshake
  // once it heads the queue; two items queued with a stalled sink means both stages are full.
  logic             prevStall;
  logic [BWT-1:0]   pBw;
  logic [MIDT-1:0]  pMid;
  logic [31:0]      pConv;
  logic [BOOLT-1:0] pBool;
  logic             pErr;
  logic             expV;
  item_t            f;

  initial begin
    prevStall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        q.delete();
        prevStall = 1'b0;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_err", out_err, 0);
        checkOutput("rst_mid", mid_out, 0);
        checkOutput("rst_bw", bw_out, 0);
        checkOutput("rst_conv", conv_out, 0);
        checkOutput("rst_bool", bool_out, 0);
      end else begin
        expV = (q.size() > 0) && (q[0].cycle + 2 <= cyc);
        checkOutput("out_valid", out_valid, expV);
        checkOutput("in_ready", in_ready, !flush && !(q.size() == 2 && !out_ready));
        if (prevStall) begin
          checkOutput("stall_mid", mid_out, pMid);
          checkOutput("stall_bw", bw_out, pBw);
          checkOutput("stall_conv", conv_out, pConv);
          checkOutput("stall_bool", bool_out, pBool);
          checkOutput("stall_err", out_err, pErr);
        end
        if (out_valid && q.size() > 0) begin
          f = q[0];
          checkOutput("data_mid", mid_out, f.mid);
          checkOutput("data_bw", bw_out, f.bw);
          checkOutput("data_conv", conv_out, f.conv);
          checkOutput("data_bool", bool_out, f.boolV);
          checkOutput("data_err", out_err, f.err);
          if (out_ready) void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(modelOf(cyc));
        prevStall = out_valid && !out_ready && !flush;
        pBw = bw_out; pMid = mid_out; pConv = conv_out; pBool = bool_out; pErr = out_err;
      end
    end
  end

  task automatic applyStimulus();
    int n;
    for (int i = 0; i < MAX_WORDS; i++) begin
      mid_in[i*WORD_W +: WORD_W] = $urandom;
      bw_in[i*BW_W +: BW_W]      = 5'($urandom_range(0, 31));
      bool_in[i*BPW +: BPW]      = 4'($urandom_range(0, 15));
    end
    conv_in = $urandom;
    rot_dir = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) begin
      n         = $urandom_range(1, 32);
      num_words = 6'(n);
      rot_amt   = 5'($urandom_range(0, n - 1));
    end else begin
      num_words = 6'($urandom_range(0, 63));
      rot_amt   = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request on an idle pipeline; leaves the bench at the negedge where it shows.
  task automatic sendOne(input string tag);
    in_valid = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_lat"}, out_valid, 1);
  endtask

  logic [BWT-1:0]  expBw;
  logic [MIDT-1:0] expMid;
  int              vals[5] = '{4, 5, 1, 2, 3};
  int              pat[4]  = '{1, 0, 0, 1};
  int              sent, pi, guard;
  logic            acc, sawFull, sawValid;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus();
    repeat (3) nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("post_reset_ready", in_ready, 1);

    // Full block, rotate toward LSB by 3, mid word i = i.
    applyStimulus();
    for (int i = 0; i < MAX_WORDS; i++) mid_in[i*WORD_W +: WORD_W] = i;
    num_words = 6'd32; rot_amt = 5'd3; rot_dir = 1'b0;
    expMid = '0;
    for (int i = 0; i < MAX_WORDS; i++) expMid[i*WORD_W +: WORD_W] = (i + 3) % 32;
    sendOne("r038");
    checkOutput("r038_mid", mid_out, expMid);
    checkOutput("r038_err", out_err, 0);
    nextCycle();

    // Five words rotated toward MSB by 2.
    applyStimulus();
    for (int i = 0; i < MAX_WORDS; i++) bw_in[i*BW_W +: BW_W] = (i < 5) ? 5'(i + 1) : 5'd31;
    num_words = 6'd5; rot_amt = 5'd2; rot_dir = 1'b1;
    expBw = '0;
    for (int i = 0; i < 5; i++) expBw[i*BW_W +: BW_W] = 5'(vals[i]);
    sendOne("r039");
    checkOutput("r039_bw", bw_out, expBw);
    checkOutput("r039_midhi", mid_out >> 160, 0);
    nextCycle();

    // Rotation equal to N is illegal; an unrotated legal request follows.
    applyStimulus();
    num_words = 6'd4; rot_amt = 5'd4; rot_dir = 1'b0;
    sendOne("r040");
    checkOutput("r040_err", out_err, 1);
    checkOutput("r040_mid", mid_out, 0);
    checkOutput("r040_bw", bw_out, 0);
    checkOutput("r040_conv", conv_out, 0);
    checkOutput("r040_bool", bool_out, 0);
    nextCycle();
    applyStimulus();
    num_words = 6'd4; rot_amt = 5'd0;
    expMid = '0;
    expMid[127:0] = mid_in[127:0];
    sendOne("r026");
    checkOutput("r026_err", out_err, 0);
    checkOutput("r026_mid", mid_out, expMid);
    nextCycle();

    // Eight back-to-back transfers against a 1,0,0,1 sink pattern.
    sent = 0; pi = 0; guard = 0; sawFull = 1'b0;
    applyStimulus();
    in_valid = 1'b1;
    while (sent < 8 && guard < 100) begin
      out_ready = (pat[pi % 4] != 0);
      pi++;
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) sawFull = 1'b1;
      nextCycle();
      if (acc) begin
        sent++;
        if (sent < 8) applyStimulus();
      end
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("r041_sent", sent, 8);
    checkOutput("r041_backpressure", sawFull, 1);
    repeat (5) nextCycle();
    checkOutput("r041_drained", q.size(), 0);

    // Reset with two transfers in flight.
    out_ready = 1'b0;
    applyStimulus(); in_valid = 1'b1; nextCycle();
    applyStimulus(); nextCycle();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("r042_async_valid", out_valid, 0);
    checkOutput("r042_async_mid", mid_out, 0);
    checkOutput("r042_async_err", out_err, 0);
    @(negedge clk);
    nextCycle();
    rst = 1'b1; out_ready = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("r042_no_emit", sawValid, 0);
    nextCycle();

    // Flush with both stages full; in_valid held high through the flush cycle.
    out_ready = 1'b0;
    applyStimulus(); in_valid = 1'b1; nextCycle();
    applyStimulus(); nextCycle();
    flush = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("r043_ready_flush", in_ready, 0);
    nextCycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("r043_flushed", out_valid, 0);
    nextCycle();
    applyStimulus();
    num_words = 6'd8; rot_amt = 5'd1; rot_dir = 1'b0;
    sendOne("r043");
    nextCycle();

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      applyStimulus();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      nextCycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) nextCycle();
    @(negedge clk);
    checkOutput("final_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
